uart_mmio_bridge: RTL and testbench

// Memory-mapped UART bridge downstream of the control decoder. Consumes WEUART/REUART/UARTsel

---
 rtl/uart_mmio_bridge.sv | 117 +++++++++++
 tb/tb_uart_mmio_bridge.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: memory-mapped UART bridge. It holds one transmit byte for the
// transmitter and buffers received bytes in a small FIFO. Loads return a
// zero-extended 32-bit word that is selected by UARTsel.
module uart_mmio_bridge #(
  parameter int RX_DEPTH = 4,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              WEUART,
  input  logic              REUART,
  input  logic [1:0]        UARTsel,
  input  logic [DATA_W-1:0] wdata,
  output logic [31:0]       rdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam int PW = $clog2(RX_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RX_DEPTH);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} tx_state_t;

  tx_state_t         tx_state, tx_state_next;
  logic [DATA_W-1:0] tx_hold, tx_hold_next;
  logic              tx_drop, tx_drop_next;

  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push, pop;

  assign tx_valid = (tx_state == FULL);
  assign tx_data  = tx_hold;

  // TX holding register state, byte and sticky drop flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= EMPTY;
      tx_hold  <= '0;
      tx_drop  <= 1'b0;
    end else begin
      tx_state <= tx_state_next;
      tx_hold  <= tx_hold_next;
      tx_drop  <= tx_drop_next;
    end
  end

  // TX next state: load when empty or being drained, drop a store while stalled
  always_comb begin
    tx_state_next = tx_state;
    tx_hold_next  = tx_hold;
    tx_drop_next  = tx_drop;
    unique case (tx_state)
      EMPTY: begin
        if (WEUART) begin
          tx_state_next = FULL;
          tx_hold_next  = wdata;
        end
      end
      FULL: begin
        if (tx_ready) begin
          if (WEUART) tx_hold_next  = wdata;
          else        tx_state_next = EMPTY;
        end else if (WEUART) begin
          tx_drop_next = 1'b1;
        end
      end
      default: tx_state_next = EMPTY;
    endcase
  end

  assign rx_ready = (count != FULL_CNT);
  assign push     = rx_valid && rx_ready;
  // An empty FIFO cannot be popped, so a byte pushed in the same cycle is not bypassed
  assign pop      = REUART && (count != '0);

  // RX FIFO storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push) rx_mem[wr_ptr] <= rx_data;
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Load data mux; a read shows the pre-pop head
  always_comb begin
    rdata = '0;
    unique case (UARTsel)
      2'b00: rdata = (count != '0) ? 32'(rx_mem[rd_ptr]) : 32'd0;
      2'b01: rdata = {31'b0, ~tx_valid};
      2'b10: rdata = {31'b0, (count != '0)};
      2'b11: rdata = {16'(count), 15'b0, tx_drop};
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// tb_uart_mmio_bridge: table-driven directed vectors, hand sequences for FIFO
// and reset corner cases, then randomized traffic against a queue-based model.
module tb_uart_mmio_bridge;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic        WEUART, REUART;
  logic [1:0]  UARTsel;
  logic [7:0]  wdata;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;

  int vectors;
  int miscompares;

  // Reference model state
  logic [7:0] mq[$];
  logic       m_txv;
  logic [7:0] m_txd;
  logic       m_drop;

  uart_mmio_bridge #(.RX_DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .WEUART(WEUART), .REUART(REUART),
    .UARTsel(UARTsel), .wdata(wdata), .rdata(rdata), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we, re;
    logic [1:0]  sel;
    logic [7:0]  wd;
    logic        txr, rxv;
    logic [7:0]  rxd;
    logic [31:0] exp_rdata;
    logic        exp_txv;
    logic [7:0]  exp_txd;
    logic        exp_rxr;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic we, logic re, logic [1:0] sel, logic [7:0] wd,
                              logic txr, logic rxv, logic [7:0] rxd,
                              logic [31:0] er, logic etv, logic [7:0] etd, logic err);
    vec_t v;
    v.we = we; v.re = re; v.sel = sel; v.wd = wd; v.txr = txr; v.rxv = rxv; v.rxd = rxd;
    v.exp_rdata = er; v.exp_txv = etv; v.exp_txd = etd; v.exp_rxr = err;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic si(logic we, logic re, logic [1:0] sel, logic [7:0] wd,
                    logic txr, logic rxv, logic [7:0] rxd);
    WEUART = we; REUART = re; UARTsel = sel; wdata = wd;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    #1;
  endtask

  function automatic logic [31:0] model_rdata(logic [1:0] sel);
    case (sel)
      2'b00:   return (mq.size() != 0) ? {24'b0, mq[0]} : 32'd0;
      2'b01:   return {31'b0, ~m_txv};
      2'b10:   return {31'b0, mq.size() != 0};
      default: return {16'(mq.size()), 15'b0, m_drop};
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_txv = 1'b0; m_txd = 8'h00; m_drop = 1'b0;
  endtask

  // Compare against the model, take one clock edge, advance the model
  task automatic adv();
    logic do_push, do_pop;
    check("m_rdata",    rdata,    model_rdata(UARTsel));
    check("m_tx_valid", 32'(tx_valid), 32'(m_txv));
    check("m_tx_data",  32'(tx_data),  32'(m_txd));
    check("m_rx_ready", 32'(rx_ready), 32'(mq.size() != DEPTH));
    do_push = rx_valid && (mq.size() != DEPTH);
    do_pop  = REUART && (mq.size() != 0);
    @(posedge clk);
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back(rx_data);
    if (!m_txv) begin
      if (WEUART) begin m_txv = 1'b1; m_txd = wdata; end
    end else if (tx_ready) begin
      if (WEUART) m_txd = wdata;
      else        m_txv = 1'b0;
    end else if (WEUART) begin
      m_drop = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_reset();
    reset_n = 1'b0;
    WEUART = 0; REUART = 0; UARTsel = 2'b01; wdata = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;

    //             we re sel    wd    txr rxv rxd    rdata         txv txd    rxr
    tbl[0]  = mk(0, 0, 2'b01, 8'h00, 0, 0, 8'h00, 32'h1,        0, 8'h00, 1);
    tbl[1]  = mk(1, 0, 2'b01, 8'h41, 0, 0, 8'h00, 32'h1,        0, 8'h00, 1);
    tbl[2]  = mk(0, 0, 2'b01, 8'h00, 0, 0, 8'h00, 32'h0,        1, 8'h41, 1);
    tbl[3]  = mk(0, 0, 2'b01, 8'h00, 1, 0, 8'h00, 32'h0,        1, 8'h41, 1);
    tbl[4]  = mk(0, 0, 2'b01, 8'h00, 0, 0, 8'h00, 32'h1,        0, 8'h41, 1);
    tbl[5]  = mk(1, 0, 2'b11, 8'h41, 0, 0, 8'h00, 32'h0,        0, 8'h41, 1);
    tbl[6]  = mk(1, 0, 2'b11, 8'h42, 1, 0, 8'h00, 32'h0,        1, 8'h41, 1);
    tbl[7]  = mk(1, 0, 2'b11, 8'h43, 0, 0, 8'h00, 32'h0,        1, 8'h42, 1);
    tbl[8]  = mk(0, 0, 2'b11, 8'h00, 0, 0, 8'h00, 32'h1,        1, 8'h42, 1);
    tbl[9]  = mk(0, 0, 2'b11, 8'h00, 1, 0, 8'h00, 32'h1,        1, 8'h42, 1);
    tbl[10] = mk(0, 0, 2'b10, 8'h00, 0, 1, 8'h10, 32'h0,        0, 8'h42, 1);
    tbl[11] = mk(0, 0, 2'b10, 8'h00, 0, 1, 8'h11, 32'h1,        0, 8'h42, 1);
    tbl[12] = mk(0, 0, 2'b00, 8'h00, 0, 1, 8'h12, 32'h10,       0, 8'h42, 1);
    tbl[13] = mk(0, 0, 2'b11, 8'h00, 0, 1, 8'h13, 32'h00030001, 0, 8'h42, 1);
    tbl[14] = mk(0, 0, 2'b11, 8'h00, 0, 1, 8'h14, 32'h00040001, 0, 8'h42, 0);
    tbl[15] = mk(0, 1, 2'b00, 8'h00, 0, 1, 8'h14, 32'h10,       0, 8'h42, 0);
    tbl[16] = mk(0, 1, 2'b00, 8'h00, 0, 0, 8'h00, 32'h11,       0, 8'h42, 1);
    tbl[17] = mk(0, 1, 2'b00, 8'h00, 0, 0, 8'h00, 32'h12,       0, 8'h42, 1);
    tbl[18] = mk(0, 1, 2'b00, 8'h00, 0, 0, 8'h00, 32'h13,       0, 8'h42, 1);
    tbl[19] = mk(0, 0, 2'b10, 8'h00, 0, 0, 8'h00, 32'h0,        0, 8'h42, 1);
    tbl[20] = mk(0, 1, 2'b00, 8'h00, 0, 0, 8'h00, 32'h0,        0, 8'h42, 1);
    tbl[21] = mk(0, 0, 2'b11, 8'h00, 0, 0, 8'h00, 32'h00000001, 0, 8'h42, 1);

    // T1: values while reset is held
    @(negedge clk);
    si(0, 0, 2'b01, 8'h00, 0, 0, 8'h00);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_sel01", rdata, 32'd1);
    si(0, 0, 2'b10, 8'h00, 0, 0, 8'h00);
    check("rst_sel10", rdata, 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // T2..T5 directed table
    for (int i = 0; i < 22; i++) begin
      si(tbl[i].we, tbl[i].re, tbl[i].sel, tbl[i].wd, tbl[i].txr, tbl[i].rxv, tbl[i].rxd);
      check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_tx_valid", i), 32'(tx_valid), 32'(tbl[i].exp_txv));
      check($sformatf("tbl%0d_tx_data", i), 32'(tx_data), 32'(tbl[i].exp_txd));
      check($sformatf("tbl%0d_rx_ready", i), 32'(rx_ready), 32'(tbl[i].exp_rxr));
      adv();
    end

    // T5: simultaneous push and pop at count 2
    si(0, 0, 2'b10, 8'h00, 0, 1, 8'hA0); adv();
    si(0, 0, 2'b10, 8'h00, 0, 1, 8'hA1); adv();
    si(0, 1, 2'b00, 8'h00, 0, 1, 8'h20);
    check("pp_head", rdata, 32'hA0);
    adv();
    si(0, 0, 2'b11, 8'h00, 0, 0, 8'h00);
    check("pp_count", rdata, 32'h00020001);
    adv();
    si(0, 1, 2'b00, 8'h00, 0, 0, 8'h00);
    check("pp_pop1", rdata, 32'hA1);
    adv();
    si(0, 1, 2'b00, 8'h00, 0, 0, 8'h00);
    check("pp_pop2", rdata, 32'h20);
    adv();
    si(0, 0, 2'b10, 8'h00, 0, 0, 8'h00);
    check("pp_empty", rdata, 32'h0);
    adv();

    // T5: pointer wrap over six push/pop pairs
    for (int i = 0; i < 6; i++) begin
      si(0, 0, 2'b10, 8'h00, 0, 1, 8'(8'h50 + i)); adv();
      si(0, 1, 2'b00, 8'h00, 0, 0, 8'h00);
      check($sformatf("wrap%0d", i), rdata, 32'(8'h50 + i));
      adv();
    end

    // T6: reset in the middle of activity
    si(1, 0, 2'b11, 8'h77, 0, 1, 8'h30); adv();
    si(0, 0, 2'b11, 8'h00, 0, 1, 8'h31); adv();
    si(0, 0, 2'b11, 8'h00, 0, 1, 8'h32); adv();
    si(0, 0, 2'b11, 8'h00, 0, 0, 8'h00);
    check("pre_rst_status", rdata, 32'h00030001);
    check("pre_rst_tx_valid", 32'(tx_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_rx_ready", 32'(rx_ready), 32'd1);
    check("mid_rst_status", rdata, 32'd0);
    si(0, 0, 2'b01, 8'h00, 0, 0, 8'h00);
    check("mid_rst_sel01", rdata, 32'd1);
    si(0, 0, 2'b10, 8'h00, 0, 0, 8'h00);
    check("mid_rst_sel10", rdata, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      si(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
         8'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 8'($urandom));
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
